// File: rtl/mc_request_queue_if.sv
// Parser-side and sequencer-side handshake bundle for mc_request_queue.
interface mc_request_queue_if #(
    parameter int ADDR_WIDTH  = 36,
    parameter int MEMOP_WIDTH = 12,
    parameter int TIME_WIDTH  = 12
);
    localparam int LINE_W = TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH;

    logic                   data_req;
    logic                   data_rdy;
    logic [LINE_W-1:0]      data_read;
    logic                   issue_valid;
    logic                   issue_ready;
    logic [MEMOP_WIDTH-1:0] issue_cmd;
    logic [ADDR_WIDTH-1:0]  issue_addr;
    logic [TIME_WIDTH-1:0]  issue_time;

    modport slave (
        output data_req,
        input  data_rdy,
        input  data_read,
        output issue_valid,
        input  issue_ready,
        output issue_cmd,
        output issue_addr,
        output issue_time
    );

    modport master (
        input  data_req,
        output data_rdy,
        output data_read,
        input  issue_valid,
        output issue_ready,
        input  issue_cmd,
        input  issue_addr,
        input  issue_time
    );
endinterface

// File: rtl/mc_request_queue.sv
// In-order request queue / issue scheduler with shutdown drain.
// Optional same-cycle empty-queue bypass: define MC_REQQ_BYPASS_EN.
module mc_request_queue #(
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = 36,
    parameter int MEMOP_WIDTH = 12,
    parameter int TIME_WIDTH  = 12,
    parameter int CYCLE_WIDTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CYCLE_WIDTH-1:0] cycle,
    input  logic                   shutdown,
    mc_request_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_overflow,
    output logic                   err_illegal,
    output logic                   done
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LINE_W = TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LINE_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;

    logic [LINE_W-1:0]      head;
    logic [TIME_WIDTH-1:0]  head_time;
    logic [MEMOP_WIDTH-1:0] in_cmd;
    logic                   in_legal;
    logic                   empty;
    logic                   full;
    logic                   run;
    logic                   take;
    logic                   head_elig;
    logic                   bypass;
    logic                   issue_fire;
    logic                   push;
    logic                   pop;
    logic [LINE_W-1:0]      fields;

    assign head      = mem_q[rd_ptr_q];
    assign head_time = head[LINE_W-1 -: TIME_WIDTH];
    assign in_cmd    = bus.data_read[ADDR_WIDTH +: MEMOP_WIDTH];
    assign in_legal  = (in_cmd <= MEMOP_WIDTH'(2));

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign run   = (state_q == S_RUN);
    assign take  = run && bus.data_rdy;

    assign head_elig = !empty &&
        (CYCLE_WIDTH'(head_time) <= cycle);

`ifdef MC_REQQ_BYPASS_EN
    logic [TIME_WIDTH-1:0] in_time;
    assign in_time = bus.data_read[LINE_W-1 -: TIME_WIDTH];
`endif

    always_comb begin
        bypass = 1'b0;
        fields = empty ? '0 : head;
`ifdef MC_REQQ_BYPASS_EN
        bypass = take && empty && in_legal &&
            (CYCLE_WIDTH'(in_time) <= cycle);
        if (bypass) fields = bus.data_read;
`endif
    end

    assign bus.issue_valid = head_elig || bypass;
    assign bus.issue_time  = fields[LINE_W-1 -: TIME_WIDTH];
    assign bus.issue_cmd   = fields[ADDR_WIDTH +: MEMOP_WIDTH];
    assign bus.issue_addr  = fields[ADDR_WIDTH-1:0];

    assign issue_fire = bus.issue_valid && bus.issue_ready;
    assign pop        = head_elig && bus.issue_ready;

    // A bypassed line that the sequencer takes is never written.
    assign push = take && !full && in_legal &&
        !(bypass && bus.issue_ready);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d    = ovf_q | (take & full);
        ill_d    = ill_q | (take & ~in_legal);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   if (shutdown) state_d = S_DRAIN;
            S_DRAIN: if (empty && !issue_fire) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= bus.data_read;
    end

    // One slot of slack covers a line already in flight.
    assign bus.data_req = run && (count_q < CNT_W'(DEPTH - 1));

    assign count        = count_q;
    assign err_overflow = ovf_q;
    assign err_illegal  = ill_q;
    assign done         = (state_q == S_DONE);
endmodule

// File: tb/tb_mc_request_queue.sv
// Self-checking bench for mc_request_queue against a queue-based model.
// Bypass expectations follow MC_REQQ_BYPASS_EN.
module tb_mc_request_queue;
    localparam int DEPTH = 16;
    localparam int AW    = 36;
    localparam int MW    = 12;
    localparam int TW    = 12;
    localparam int CW    = 64;
    localparam int LW    = TW + MW + AW;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_t;

    logic            clock = 1'b0;
    logic            reset;
    logic [CW-1:0]   cycle;
    logic            shutdown;
    logic [CNTW-1:0] count;
    logic            err_overflow;
    logic            err_illegal;
    logic            done;

    mc_request_queue_if #(
        .ADDR_WIDTH(AW), .MEMOP_WIDTH(MW), .TIME_WIDTH(TW)
    ) bus ();

    mc_request_queue #(
        .DEPTH(DEPTH), .ADDR_WIDTH(AW), .MEMOP_WIDTH(MW),
        .TIME_WIDTH(TW), .CYCLE_WIDTH(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cycle(cycle),
        .shutdown(shutdown),
        .bus(bus),
        .count(count),
        .err_overflow(err_overflow),
        .err_illegal(err_illegal),
        .done(done)
    );

    always #5 clock = ~clock;

    mstate_t        ms;
    logic [LW-1:0]  mq[$];
    bit             m_ovf, m_ill;
    logic [CW-1:0]  cyc;
    int             n_chk, n_fail;

    bit             e_req, e_valid, e_byp, e_done;
    logic [LW-1:0]  e_line;
    int             e_count;

    function automatic logic [LW-1:0] mk(input logic [TW-1:0] t,
                                         input logic [MW-1:0] c,
                                         input logic [AW-1:0] a);
        return {t, c, a};
    endfunction

    task automatic drive(input bit rdy, input logic [LW-1:0] line,
                         input bit rd, input bit sh);
        logic [TW-1:0] lt;
        logic [MW-1:0] lc;
        bus.data_rdy    = rdy;
        bus.data_read   = line;
        bus.issue_ready = rd;
        shutdown        = sh;
        cycle           = cyc;
        #1;
        lt = line[LW-1 -: TW];
        lc = line[AW +: MW];
        e_req = (ms == M_RUN) && (mq.size() < DEPTH - 1);
        e_byp = 1'b0;
`ifdef MC_REQQ_BYPASS_EN
        e_byp = (ms == M_RUN) && (mq.size() == 0) && rdy &&
                (lc <= 2) && (CW'(lt) <= cyc);
`endif
        e_valid = e_byp ||
                  ((mq.size() > 0) && (CW'(mq[0][LW-1 -: TW]) <= cyc));
        e_line  = e_byp ? line : ((mq.size() > 0) ? mq[0] : '0);
        e_count = mq.size();
        e_done  = (ms == M_DONE);
    endtask

    task automatic step();
        int sz;
        bit legal;
        sz    = mq.size();
        legal = (bus.data_read[AW +: MW] <= 2);
        if (e_valid && bus.issue_ready && !e_byp) void'(mq.pop_front());
        if (ms == M_RUN && bus.data_rdy) begin
            if (sz == DEPTH) m_ovf = 1'b1;
            if (!legal) m_ill = 1'b1;
            if (sz != DEPTH && legal && !(e_byp && bus.issue_ready))
                mq.push_back(bus.data_read);
        end
        case (ms)
            M_IDLE:  ms = M_RUN;
            M_RUN:   if (shutdown) ms = M_DRAIN;
            M_DRAIN: if (sz == 0) ms = M_DONE;
            default: ms = ms;
        endcase
        @(posedge clock);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic apply_reset();
        reset           = 1'b1;
        bus.data_rdy    = 1'b0;
        bus.data_read   = '0;
        bus.issue_ready = 1'b0;
        shutdown        = 1'b0;
        #1;
        mq.delete();
        ms    = M_IDLE;
        m_ovf = 1'b0;
        m_ill = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = '0;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.data_rdy    = 1'b1;
        bus.data_read   = mk(0, 0, 36'h1);
        bus.issue_ready = 1'b1;
        shutdown        = 1'b0;
        cycle           = 64'd100;
        #1;
        n_chk++; if (bus.data_req !== 1'b0) begin n_fail++;
            $display("FAIL reset_data_req got %b exp 0", bus.data_req); end
        n_chk++; if (bus.issue_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_issue_valid got %b exp 0", bus.issue_valid); end
        n_chk++; if (bus.issue_cmd !== '0) begin n_fail++;
            $display("FAIL reset_issue_cmd got %h exp 0", bus.issue_cmd); end
        n_chk++; if (bus.issue_addr !== '0) begin n_fail++;
            $display("FAIL reset_issue_addr got %h exp 0", bus.issue_addr); end
        n_chk++; if (bus.issue_time !== '0) begin n_fail++;
            $display("FAIL reset_issue_time got %h exp 0", bus.issue_time); end
        n_chk++; if (count !== '0) begin n_fail++;
            $display("FAIL reset_count got %0d exp 0", count); end
        n_chk++; if (err_overflow !== 1'b0) begin n_fail++;
            $display("FAIL reset_err_overflow got %b exp 0", err_overflow); end
        n_chk++; if (err_illegal !== 1'b0) begin n_fail++;
            $display("FAIL reset_err_illegal got %b exp 0", err_illegal); end
        n_chk++; if (done !== 1'b0) begin n_fail++;
            $display("FAIL reset_done got %b exp 0", done); end
        apply_reset();
        drive(0, '0, 0, 0);
        n_chk++; if (bus.data_req !== 1'b0) begin n_fail++;
            $display("FAIL idle_data_req got %b exp 0", bus.data_req); end
        step();
        drive(0, '0, 0, 0);
        n_chk++; if (bus.data_req !== 1'b1) begin n_fail++;
            $display("FAIL run_data_req got %b exp 1", bus.data_req); end
    endtask

    task automatic test_in_order();
        apply_reset();
        drive(0, '0, 1, 0); step();
        drive(0, '0, 1, 0); step();
        drive(1, mk(5, 0, 36'h0_0000_1000), 1, 0); step();
        drive(1, mk(5, 1, 36'h0_0000_2000), 1, 0); step();
        for (int k = 0; k < 5; k++) begin
            drive(0, '0, 1, 0);
            n_chk++; if (bus.issue_valid !== e_valid) begin n_fail++;
                $display("FAIL order_valid cyc=%0d got %b exp %b",
                         cyc, bus.issue_valid, e_valid); end
            if (cyc == 5 || cyc == 6) begin
                n_chk++;
                if (bus.issue_valid !== 1'b1 || bus.issue_addr !==
                    ((cyc == 5) ? 36'h1000 : 36'h2000)) begin
                    n_fail++;
                    $display("FAIL order_issue cyc=%0d got v=%b a=%h",
                             cyc, bus.issue_valid, bus.issue_addr);
                end
            end
            step();
        end
        drive(0, '0, 1, 0);
        n_chk++; if (count !== 0) begin n_fail++;
            $display("FAIL order_count got %0d exp 0", count); end
    endtask

    task automatic test_blocking();
        bit want;
        apply_reset();
        drive(0, '0, 1, 0); step();
        cyc = 10;
        drive(1, mk(100, 2, 36'hABC), 1, 0); step();
        drive(1, mk(3, 0, 36'h10), 1, 0); step();
        while (cyc <= 120) begin
            drive(0, '0, 1, 0);
            want = (cyc == 100) || (cyc == 101);
            n_chk++; if (bus.issue_valid !== want) begin n_fail++;
                $display("FAIL block_valid cyc=%0d got %b exp %b",
                         cyc, bus.issue_valid, want); end
            if (e_valid) begin
                n_chk++;
                if ({bus.issue_time, bus.issue_cmd, bus.issue_addr}
                    !== e_line) begin
                    n_fail++;
                    $display("FAIL block_fields got %h exp %h",
                             {bus.issue_time, bus.issue_cmd,
                              bus.issue_addr}, e_line);
                end
            end
            step();
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        drive(0, '0, 0, 0); step();
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive(1, mk(TW'($urandom), MW'($urandom_range(0, 2)),
                        AW'($urandom)), 0, 0);
            n_chk++;
            if (bus.data_req !== e_req || count !== CNTW'(e_count)) begin
                n_fail++;
                $display("FAIL fill i=%0d got req=%b cnt=%0d exp %b %0d",
                         i, bus.data_req, count, e_req, e_count);
            end
            step();
        end
        drive(0, '0, 0, 0);
        n_chk++; if (bus.data_req !== 1'b0) begin n_fail++;
            $display("FAIL fill_data_req got %b exp 0", bus.data_req); end
        drive(1, mk(1, 1, 36'h16), 0, 0); step();
        drive(1, mk(1, 1, 36'h17), 0, 0); step();
        drive(0, '0, 0, 0);
        n_chk++; if (count !== CNTW'(16)) begin n_fail++;
            $display("FAIL ovf_count got %0d exp 16", count); end
        n_chk++; if (err_overflow !== 1'b1) begin n_fail++;
            $display("FAIL ovf_flag got %b exp 1", err_overflow); end
        n_chk++; if (err_illegal !== 1'b0) begin n_fail++;
            $display("FAIL ovf_illegal got %b exp 0", err_illegal); end
    endtask

    task automatic test_illegal();
        apply_reset();
        drive(0, '0, 0, 0); step();
        drive(1, mk(12'hFFF, 0, 36'h44), 1, 0); step();
        drive(1, mk(1, 7, 36'h55), 1, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 0);
            n_chk++; if (count !== CNTW'(1)) begin n_fail++;
                $display("FAIL illegal_count got %0d exp 1", count); end
            n_chk++; if (err_illegal !== 1'b1) begin n_fail++;
                $display("FAIL illegal_flag got %b exp 1", err_illegal); end
            step();
        end
        apply_reset();
        drive(0, '0, 0, 0);
        n_chk++; if (err_illegal !== 1'b0) begin n_fail++;
            $display("FAIL illegal_cleared got %b exp 0", err_illegal); end
    endtask

    task automatic test_drain(input bit mid_reset);
        int n_iss, last_iss, first_done;
        bit rd;
        apply_reset();
        drive(0, '0, 0, 0); step();
        for (int i = 0; i < 4; i++) begin
            drive(1, mk(0, MW'(i % 3), AW'(36'h100 + i)), 0, 0); step();
        end
        n_iss = 0; last_iss = -1; first_done = -1; rd = 1'b1;
        drive(0, '0, rd, 1);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) drive(1, mk(0, 0, AW'($urandom)), rd, 1);
            if (mid_reset && k == 2) begin
                reset = 1'b1;
                #1;
                n_chk++;
                if ({bus.data_req, bus.issue_valid, err_overflow,
                     err_illegal, done} !== 5'b0 || count !== '0 ||
                    {bus.issue_cmd, bus.issue_addr, bus.issue_time}
                    !== '0) begin
                    n_fail++;
                    $display("FAIL midreset_outputs req=%b v=%b cnt=%0d d=%b",
                             bus.data_req, bus.issue_valid, count, done);
                end
                break;
            end
            n_chk++;
            if (count !== CNTW'(e_count) || bus.issue_valid !== e_valid ||
                done !== e_done) begin
                n_fail++;
                $display("FAIL drain k=%0d got c=%0d v=%b d=%b exp %0d %b %b",
                         k, count, bus.issue_valid, done,
                         e_count, e_valid, e_done);
            end
            if (bus.issue_valid && rd) begin n_iss++; last_iss = k; end
            if (done && first_done < 0) first_done = k;
            step();
            rd = !rd;
        end
        if (mid_reset) begin
            apply_reset();
        end else begin
            n_chk++; if (n_iss !== 4) begin n_fail++;
                $display("FAIL drain_issued got %0d exp 4", n_iss); end
            n_chk++; if (first_done !== last_iss + 2) begin n_fail++;
                $display("FAIL drain_done_cycle got %0d exp %0d",
                         first_done, last_iss + 2); end
        end
    endtask

    task automatic test_bypass();
        apply_reset();
        drive(0, '0, 1, 0); step();
        cyc = 50;
        drive(1, mk(40, 0, 36'h20), 1, 0);
`ifdef MC_REQQ_BYPASS_EN
        n_chk++;
        if (bus.issue_valid !== 1'b1 || bus.issue_addr !== 36'h20) begin
            n_fail++;
            $display("FAIL bypass_same got v=%b a=%h exp 1 20",
                     bus.issue_valid, bus.issue_addr);
        end
        step();
        drive(0, '0, 1, 0);
        n_chk++; if (count !== 0) begin n_fail++;
            $display("FAIL bypass_count got %0d exp 0", count); end
`else
        n_chk++; if (bus.issue_valid !== 1'b0) begin n_fail++;
            $display("FAIL nobypass_same got %b exp 0", bus.issue_valid); end
        step();
        drive(0, '0, 1, 0);
        n_chk++;
        if (bus.issue_valid !== 1'b1 || bus.issue_addr !== 36'h20 ||
            count !== CNTW'(1)) begin
            n_fail++;
            $display("FAIL nobypass_next got v=%b a=%h c=%0d exp 1 20 1",
                     bus.issue_valid, bus.issue_addr, count);
        end
        step();
        drive(0, '0, 1, 0);
        n_chk++; if (count !== 0) begin n_fail++;
            $display("FAIL nobypass_count got %0d exp 0", count); end
`endif
    endtask

    task automatic test_random();
        bit rdy, rd, sh;
        logic [MW-1:0] c;
        logic [TW-1:0] t;
        apply_reset();
        sh = 1'b0;
        for (int i = 0; i < 500; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 9) < ((i / 60) % 2 == 0 ? 7 : 2));
            c   = ($urandom_range(0, 11) == 0) ? MW'(3 + $urandom_range(0, 9))
                                              : MW'($urandom_range(0, 2));
            t   = TW'(cyc + 64'($urandom_range(0, 8)) - 64'd4);
            if (i > 440) sh = 1'b1;
            drive(rdy, mk(t, c, AW'({$urandom, $urandom})), rd, sh);
            n_chk++;
            if (bus.data_req !== e_req || bus.issue_valid !== e_valid ||
                count !== CNTW'(e_count) || err_overflow !== m_ovf ||
                err_illegal !== m_ill || done !== e_done ||
                (e_valid && {bus.issue_time, bus.issue_cmd, bus.issue_addr}
                            !== e_line)) begin
                n_fail++;
                $display("FAIL rand i=%0d req=%b/%b v=%b/%b c=%0d/%0d o=%b/%b il=%b/%b d=%b/%b f=%h/%h",
                         i, bus.data_req, e_req, bus.issue_valid, e_valid,
                         count, e_count, err_overflow, m_ovf,
                         err_illegal, m_ill, done, e_done,
                         {bus.issue_time, bus.issue_cmd, bus.issue_addr},
                         e_line);
            end
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = '0;
        test_reset();
        test_in_order();
        test_blocking();
        test_overflow();
        test_illegal();
        test_drain(1'b0);
        test_drain(1'b1);
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_request_queue.md
# mc_request_queue

In-order request queue and issue scheduler between the trace parser and the DRAM command sequencer of the memory controller. It pulls packed trace lines `{time, cmd, addr}` from the parser with a `data_req`/`data_rdy` handshake and validates the command code. It holds each request until the CPU cycle counter reaches the request's arrival time, then presents it to the sequencer with a valid/ready handshake. It also sequences an orderly shutdown: stop intake, drain, report done.

## Interface
- `DEPTH`, 16: queue entries; power of two, ≥4.
- `ADDR_WIDTH`, 36: address field width.
- `MEMOP_WIDTH`, 12: command field width.
- `TIME_WIDTH`, 12: arrival-time field width.
- `CYCLE_WIDTH`, 64: CPU cycle counter width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cycle` in CYCLE_WIDTH: current CPU cycle count.
- `data_req` out 1: queue can take another trace line.
- `data_rdy` in 1: `data_read` valid this cycle.
- `data_read` in TIME_WIDTH+MEMOP_WIDTH+ADDR_WIDTH: packed `{time, cmd, addr}`, with `time` in the MSBs.
- `shutdown` in 1: level; begin drain.
- `issue_valid` out 1: head request eligible.
- `issue_ready` in 1: sequencer accepts head.
- `issue_cmd` out MEMOP_WIDTH, `issue_addr` out ADDR_WIDTH, `issue_time` out TIME_WIDTH: head fields.
- `count` out $clog2(DEPTH)+1: occupancy.
- `err_overflow` out 1: sticky; a line arrived while full.
- `err_illegal` out 1: sticky; a line arrived with cmd > 2.
- `done` out 1: drain complete.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN: unconditionally on the first clock after reset deasserts.
  - RUN → DRAIN: when `shutdown`=1.
  - DRAIN → DONE: when `count`=0 and no issue is pending.
  - DONE: held until reset.
- **`data_req`:** 1 only in RUN with `count` < DEPTH-1. One slot of slack is kept for a line already in flight from the parser.
- **Accept:** at a posedge with `data_rdy`=1 in RUN.
  - Full (`count`=DEPTH, evaluated before this edge's issue): line dropped, `err_overflow` set.
  - cmd ∉ {0 read, 1 write, 2 ifetch}: line dropped, `err_illegal` set.
  - Otherwise: written at the tail.
  - `data_rdy` is ignored in IDLE, DRAIN and DONE.
- **Eligibility:** `issue_valid` = non-empty AND zero-extended head `time` ≤ `cycle`. Head fields are driven continuously from the head entry, show-ahead; their values are don't-care when empty.
- **Issue:** fires at a posedge with `issue_valid` && `issue_ready`; the head pops.
  - Strict FIFO order: a non-eligible head blocks younger entries.
  - Head fields must stay stable while `issue_valid`=1 and `issue_ready`=0.
- **Count:** simultaneous accept and issue in one edge leaves `count` unchanged. Pointers wrap modulo DEPTH.
- **Shutdown mid-accept:** a `data_rdy` on the same edge that RUN→DRAIN is still accepted, because the state is evaluated before the edge. Later lines are ignored.
- **Reset mid-operation:** all entries discarded, pointers cleared, sticky errors cleared.
- **Output reset values:** `data_req`=0, `issue_valid`=0, `issue_cmd`/`issue_addr`/`issue_time`=0, `count`=0, `err_overflow`=0, `err_illegal`=0, `done`=0.
- **`done`:** 1 exactly in DONE.

## Timing
- A line accepted at edge N is head-visible after edge N. `issue_valid` can rise in cycle N+1 at the earliest (without the bypass).
- Back-to-back issue: one request per cycle while the head remains eligible and `issue_ready`=1.
- `data_req` is combinational from state and `count`; it falls the same cycle `count` reaches DEPTH-1.
- `issue_valid` is combinational from head `time`, `cycle` and empty; there is no registered delay on the `cycle` compare.
- `done` rises one cycle after the edge that empties the queue in DRAIN.

## Configuration
- `MC_REQQ_BYPASS_EN`, defined:
  - Conditions: RUN, queue empty, `data_rdy`=1, legal cmd, and line `time` ≤ `cycle`.
  - Behaviour: `issue_valid` asserts in the same cycle with fields taken directly from `data_read`.
  - If `issue_ready`=1: the line issues at that edge and is not stored.
  - If `issue_ready`=0: the line is stored normally.
- Undefined: no bypass path; minimum accept-to-issue latency is 1 cycle.

## Test plan
- Reset, then lines `{5,0,0x0_0000_1000}` and `{5,1,0x0_0000_2000}` accepted at cycle 2, `issue_ready`=1 → both issue in order at `cycle`=5 and 6; `count` returns to 0.
- Head `{100,2,0xABC}` followed by `{3,0,0x10}`, `cycle` 10..120 → nothing issues until `cycle`=100; the entries then issue on consecutive edges.
- Fill DEPTH-1 with `issue_ready`=0 → `data_req`=0. Force `data_rdy` twice more → 16th line stored, 17th dropped, `err_overflow`=1, `count`=16.
- Line with cmd=7 → not stored, `count` unchanged, `err_illegal`=1 until reset.
- 4 queued eligible lines, `shutdown`=1, `issue_ready` toggled 1/0 → all 4 issue. `done`=1 one cycle after the last issue, and `data_rdy` is ignored throughout. Assert `reset` mid-drain instead → every output returns to its reset value immediately.
- With `MC_REQQ_BYPASS_EN` defined: empty queue, `cycle`=50, line `{40,0,0x20}`, `issue_ready`=1 → `issue_valid` high in the same cycle and `count` stays 0. Without the macro → `issue_valid` rises one cycle later.
